tt_um_counter_ctrl: RTL and testbench
=====================================

Name: tt_um_counter_ctrl

Overview:
Command-driven controller that sequences an 8-bit counter datapath: load, prescaled up/down run, programmable wrap limit, and one-shot count-to-limit. Host issues 3-bit opcodes with an 8-bit operand over the dedicated/bidirectional pins. The count value drives uo_out; status flags drive the upper bidir pins. It is the control layer around the free-running counter, packaged as a standalone tile.

Parameters:
WIDTH, 8, counter/operand/prescale/limit width (only 8 is supported on the tile pinout)
LIMIT_RST, 8'hFF, reset value of the limit register

Ports:
clk  input  1  system clock; single clock domain
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; when 0, all state holds
ui_in  input  8  command operand
uio_in  input  8  [3] cmd_valid, [2:0] opcode; [7:4] ignored
uio_out  output  8  [7] ack, [6] wrap, [5] running, [4] done; [3:0] tied 0
uio_oe  output  8  constant 8'hF0 ([7:4] outputs, [3:0] inputs)
uo_out  output  8  current count

Behaviour:
- Reset (async, rst_n=0): count=0, prescale=0, pcnt=0, limit=LIMIT_RST, dir=up, state=IDLE, vld_q=0, all uio_out bits 0, uo_out=0.
- Command accept: rising edge of cmd_valid (cmd_valid=1 and vld_q=0) while ena=1. vld_q<=cmd_valid every cycle regardless of ena, so a level held across ena=1 is never re-accepted. Effects are registered at the accepting edge; ack=1 for exactly the following cycle.
- Opcodes: 0 NOP; 1 LOAD count<=operand, pcnt<=0, DONE->IDLE, other states unchanged; 2 SET_PRESCALE prescale<=operand, pcnt<=0; 3 SET_LIMIT limit<=operand; 4 RUN_UP dir=up, ->RUN; 5 RUN_DOWN dir=down, ->RUN; 6 ONESHOT dir=up, ->SHOT; 7 STOP ->IDLE, count holds. RUN/ONESHOT/STOP also clear pcnt.
- Prescaler: in RUN/SHOT with ena=1, tick when pcnt==prescale, then pcnt<=0; otherwise pcnt+1. Count steps once every prescale+1 cycles; prescale=0 means every cycle. pcnt holds in IDLE/DONE.
- FSM states IDLE, RUN, SHOT, DONE:
  - IDLE: count holds.
  - RUN up, on tick: count==limit -> 0 with wrap=1 for one cycle, else count+1.
  - RUN down, on tick: count==0 -> limit with wrap=1, else count-1.
  - count>limit in RUN up: increments and wraps at 255->0 without wrap flag, then obeys limit.
  - SHOT: if count>=limit -> DONE next edge, with no step; else count+1 on tick. The first cycle with count==limit moves to DONE.
  - DONE: count holds, done=1; leaves only on a command (LOAD/STOP->IDLE, RUN_*->RUN, ONESHOT->SHOT).
- running=1 in RUN or SHOT; done=1 in DONE. Both are registered state decodes.
- A command and a tick in the same cycle: the command wins; no step that cycle.
- ena=0: no tick, no accept, all registers hold except vld_q; outputs keep their last values. ack/wrap still clear after their one cycle.
- Async reset mid-run returns every register to its reset value immediately.

Decomposition:
- Shared package/include tt_ctrl_pkg: opcode constants OP_NOP..OP_STOP, FSM state encodings, status bit indices.
- One sub-module counter8_dp: count register with load, inc, dec and limit-wrap logic; outputs count and wrap. The controller holds the FSM, prescaler, edge detect, and the config registers.

Test Plan:
- Reset, then RUN_UP with prescale=0 and limit=FF -> uo_out 0,1,2,... each cycle; after 256 steps wraps to 0 with one wrap pulse; ack is a single pulse after accept.
- SET_PRESCALE 3, LOAD 8'h10, RUN_UP -> count advances every 4th cycle: 10,11,12.
- SET_LIMIT 5, LOAD 0, RUN_DOWN -> sequence 0,5,4,3,2,1,0,5 with wrap on each 0->5 step.
- SET_LIMIT 7, LOAD 4, ONESHOT -> 4,5,6,7, then DONE with done=1, running=0, and count frozen at 7. A second ONESHOT with count=7 goes straight to DONE without stepping.
- Hold cmd_valid high across 10 cycles, and toggle ena=0 mid-run -> exactly one accept. Count and pcnt freeze while ena=0 and resume identically.
- Assert rst_n=0 asynchronously mid-RUN with count=8'h42 -> uo_out=0 and uio_out[7:4]=0 without waiting for a clock edge; limit returns to FF.

Source files
------------

// File: rtl/tt_ctrl_pkg.sv
// Shared constants for the counter controller tile: opcodes, FSM states,
// direction and status-bit positions on uio_out.
package tt_ctrl_pkg;

    localparam logic [2:0] OP_NOP          = 3'd0;
    localparam logic [2:0] OP_LOAD         = 3'd1;
    localparam logic [2:0] OP_SET_PRESCALE = 3'd2;
    localparam logic [2:0] OP_SET_LIMIT    = 3'd3;
    localparam logic [2:0] OP_RUN_UP       = 3'd4;
    localparam logic [2:0] OP_RUN_DOWN     = 3'd5;
    localparam logic [2:0] OP_ONESHOT      = 3'd6;
    localparam logic [2:0] OP_STOP         = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SHOT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam int BIT_ACK  = 7;
    localparam int BIT_WRAP = 6;
    localparam int BIT_RUN  = 5;
    localparam int BIT_DONE = 4;

endpackage

// File: rtl/counter8_dp.sv
// Counter datapath: load, increment and decrement with limit wrap.
// wrap is a one-cycle pulse on a limit-driven wrap only.
module counter8_dp #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             inc,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                count <= load_val;
            end else if (inc) begin
                // Above the limit the count rolls over naturally, no flag.
                if (count == limit) begin
                    count <= '0;
                    wrap  <= 1'b1;
                end else begin
                    count <= count + WIDTH'(1);
                end
            end else if (dec) begin
                if (count == '0) begin
                    count <= limit;
                    wrap  <= 1'b1;
                end else begin
                    count <= count - WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: rtl/tt_um_counter_ctrl.sv
// Command-driven controller around counter8_dp: edge-detected command accept,
// prescaler, configuration registers and the run/one-shot FSM.
//
// state | meaning
// IDLE  | count holds, prescaler holds
// RUN   | count steps up/down on each prescaler tick, wrapping at limit
// SHOT  | count steps up on tick until it reaches limit
// DONE  | one-shot finished, count frozen until the next command
module tt_um_counter_ctrl
    import tt_ctrl_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] LIMIT_RST = 8'hFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] ui_in,
    input  logic [7:0]       uio_in,
    output logic [7:0]       uio_out,
    output logic [7:0]       uio_oe,
    output logic [WIDTH-1:0] uo_out
);

    state_t           state, state_nxt;
    dir_t             dir, dir_nxt;
    logic [WIDTH-1:0] prescale, prescale_nxt;
    logic [WIDTH-1:0] pcnt, pcnt_nxt;
    logic [WIDTH-1:0] limit, limit_nxt;
    logic [WIDTH-1:0] count;
    logic             vld_q, ack, wrap;
    logic             dp_load, dp_inc, dp_dec;
    logic             cmd_valid, accept, tick, running, done;
    logic [2:0]       opcode;
    logic             unused_uio;

    assign cmd_valid  = uio_in[3];
    assign opcode     = uio_in[2:0];
    assign unused_uio = &{1'b0, uio_in[7:4]};
    assign accept     = ena & cmd_valid & ~vld_q;
    assign tick       = (pcnt == prescale);

    always_comb begin
        state_nxt    = state;
        dir_nxt      = dir;
        prescale_nxt = prescale;
        pcnt_nxt     = pcnt;
        limit_nxt    = limit;
        dp_load      = 1'b0;
        dp_inc       = 1'b0;
        dp_dec       = 1'b0;
        // A command takes the whole cycle: no counter step alongside it.
        if (accept) begin
            case (opcode)
                OP_LOAD: begin
                    dp_load  = 1'b1;
                    pcnt_nxt = '0;
                    if (state == ST_DONE) state_nxt = ST_IDLE;
                end
                OP_SET_PRESCALE: begin
                    prescale_nxt = ui_in;
                    pcnt_nxt     = '0;
                end
                OP_SET_LIMIT: limit_nxt = ui_in;
                OP_RUN_UP: begin
                    dir_nxt   = DIR_UP;
                    state_nxt = ST_RUN;
                    pcnt_nxt  = '0;
                end
                OP_RUN_DOWN: begin
                    dir_nxt   = DIR_DOWN;
                    state_nxt = ST_RUN;
                    pcnt_nxt  = '0;
                end
                OP_ONESHOT: begin
                    dir_nxt   = DIR_UP;
                    state_nxt = ST_SHOT;
                    pcnt_nxt  = '0;
                end
                OP_STOP: begin
                    state_nxt = ST_IDLE;
                    pcnt_nxt  = '0;
                end
                default: ;
            endcase
        end else if (ena) begin
            case (state)
                ST_RUN: begin
                    pcnt_nxt = tick ? '0 : pcnt + WIDTH'(1);
                    if (tick) begin
                        dp_inc = (dir == DIR_UP);
                        dp_dec = (dir == DIR_DOWN);
                    end
                end
                ST_SHOT: begin
                    if (count >= limit) begin
                        state_nxt = ST_DONE;
                    end else begin
                        pcnt_nxt = tick ? '0 : pcnt + WIDTH'(1);
                        dp_inc   = tick;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            dir      <= DIR_UP;
            prescale <= '0;
            pcnt     <= '0;
            limit    <= LIMIT_RST;
            vld_q    <= 1'b0;
            ack      <= 1'b0;
        end else begin
            state    <= state_nxt;
            dir      <= dir_nxt;
            prescale <= prescale_nxt;
            pcnt     <= pcnt_nxt;
            limit    <= limit_nxt;
            vld_q    <= cmd_valid;
            ack      <= accept;
        end
    end

    counter8_dp #(.WIDTH(WIDTH)) u_dp (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (dp_load),
        .inc      (dp_inc),
        .dec      (dp_dec),
        .load_val (ui_in),
        .limit    (limit),
        .count    (count),
        .wrap     (wrap)
    );

    assign running = (state == ST_RUN) || (state == ST_SHOT);
    assign done    = (state == ST_DONE);

    always_comb begin
        uio_out           = 8'h00;
        uio_out[BIT_ACK]  = ack;
        uio_out[BIT_WRAP] = wrap;
        uio_out[BIT_RUN]  = running;
        uio_out[BIT_DONE] = done;
    end

    assign uio_oe = 8'hF0;
    assign uo_out = count;

endmodule

// File: tb/tb_tt_um_counter_ctrl.sv
// Directed self-checking bench for tt_um_counter_ctrl.
module tb_tt_um_counter_ctrl;

    localparam logic [2:0] C_LOAD = 3'd1, C_PRE = 3'd2, C_LIM = 3'd3, C_UP = 3'd4,
                           C_DOWN = 3'd5, C_SHOT = 3'd6, C_STOP = 3'd7;

    logic       clk = 1'b0;
    logic       rst_n, ena;
    logic [7:0] ui_in, uio_in, uio_out, uio_oe, uo_out;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    tt_um_counter_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .uo_out  (uo_out)
    );

    // Returns #1 after the accepting edge with cmd_valid already dropped.
    task automatic send_cmd(input logic [2:0] op, input logic [7:0] val);
        uio_in = 8'h00;
        @(posedge clk); #1;
        uio_in = {4'b0000, 1'b1, op};
        ui_in  = val;
        @(posedge clk); #1;
        uio_in = 8'h00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
        #2;
        total++; if (uo_out !== 8'h00) begin bad++; $display("FAIL reset_uo got=%h exp=00", uo_out); end
        total++; if (uio_out !== 8'h00) begin bad++; $display("FAIL reset_uio got=%h exp=00", uio_out); end
        total++; if (uio_oe !== 8'hF0) begin bad++; $display("FAIL reset_oe got=%h exp=F0", uio_oe); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        total++; if (uio_out !== 8'h00) begin bad++; $display("FAIL reset_hold_uio got=%h exp=00", uio_out); end
    endtask

    task automatic test_run_up();
        logic [7:0] e;
        send_cmd(C_UP, 8'h00);
        total++; if (uio_out[7] !== 1'b1) begin bad++; $display("FAIL run_up_ack got=%b exp=1", uio_out[7]); end
        total++; if (uio_out[5] !== 1'b1) begin bad++; $display("FAIL run_up_running got=%b exp=1", uio_out[5]); end
        total++; if (uo_out !== 8'h00) begin bad++; $display("FAIL run_up_start got=%h exp=00", uo_out); end
        for (int k = 1; k <= 257; k++) begin
            @(posedge clk); #1;
            e = 8'(k);
            total++; if (uo_out !== e) begin bad++; $display("FAIL run_up_count k=%0d got=%h exp=%h", k, uo_out, e); end
            total++; if (uio_out[6] !== (k == 256)) begin bad++; $display("FAIL run_up_wrap k=%0d got=%b exp=%b", k, uio_out[6], (k == 256)); end
            if (k == 1) begin
                total++; if (uio_out[7] !== 1'b0) begin bad++; $display("FAIL run_up_ack_pulse got=%b exp=0", uio_out[7]); end
            end
        end
        send_cmd(C_STOP, 8'h00);
        total++; if (uio_out[5] !== 1'b0) begin bad++; $display("FAIL stop_running got=%b exp=0", uio_out[5]); end
    endtask

    task automatic test_prescale();
        logic [7:0] e;
        send_cmd(C_PRE, 8'd3);
        send_cmd(C_LOAD, 8'h10);
        send_cmd(C_UP, 8'h00);
        total++; if (uo_out !== 8'h10) begin bad++; $display("FAIL pre_start got=%h exp=10", uo_out); end
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            e = 8'(16 + i / 4);
            total++; if (uo_out !== e) begin bad++; $display("FAIL pre_count i=%0d got=%h exp=%h", i, uo_out, e); end
        end
        send_cmd(C_STOP, 8'h00);
        send_cmd(C_PRE, 8'd0);
    endtask

    task automatic test_run_down();
        logic [7:0] seq [8] = '{8'd0, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd5};
        logic       wr  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        send_cmd(C_LIM, 8'd5);
        send_cmd(C_LOAD, 8'd0);
        send_cmd(C_DOWN, 8'h00);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            total++; if (uo_out !== seq[i]) begin bad++; $display("FAIL down_count i=%0d got=%h exp=%h", i, uo_out, seq[i]); end
            total++; if (uio_out[6] !== wr[i]) begin bad++; $display("FAIL down_wrap i=%0d got=%b exp=%b", i, uio_out[6], wr[i]); end
        end
        send_cmd(C_STOP, 8'h00);
    endtask

    task automatic test_oneshot();
        logic [7:0] seq [7] = '{8'd4, 8'd5, 8'd6, 8'd7, 8'd7, 8'd7, 8'd7};
        logic       run [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        send_cmd(C_LIM, 8'd7);
        send_cmd(C_LOAD, 8'd4);
        send_cmd(C_SHOT, 8'h00);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            total++; if (uo_out !== seq[i]) begin bad++; $display("FAIL shot_count i=%0d got=%h exp=%h", i, uo_out, seq[i]); end
            total++; if (uio_out[5:4] !== {run[i], ~run[i]}) begin bad++; $display("FAIL shot_flags i=%0d got=%b exp=%b", i, uio_out[5:4], {run[i], ~run[i]}); end
        end
        send_cmd(C_SHOT, 8'h00);
        total++; if (uio_out[5:4] !== 2'b10 || uo_out !== 8'd7) begin bad++; $display("FAIL shot2_start got=%b/%h exp=10/07", uio_out[5:4], uo_out); end
        @(posedge clk); #1;
        total++; if (uio_out[5:4] !== 2'b01 || uo_out !== 8'd7) begin bad++; $display("FAIL shot2_done got=%b/%h exp=01/07", uio_out[5:4], uo_out); end
        send_cmd(C_LOAD, 8'h33);
        total++; if (uio_out[5:4] !== 2'b00 || uo_out !== 8'h33) begin bad++; $display("FAIL done_load got=%b/%h exp=00/33", uio_out[5:4], uo_out); end
    endtask

    task automatic test_hold_ena();
        int acks = 0;
        send_cmd(C_LIM, 8'hFF);
        send_cmd(C_LOAD, 8'h20);
        @(posedge clk); #1;
        uio_in = {4'b0000, 1'b1, C_UP};
        repeat (10) begin
            @(posedge clk); #1;
            if (uio_out[7]) acks++;
        end
        uio_in = 8'h00;
        total++; if (acks !== 1) begin bad++; $display("FAIL hold_acks got=%0d exp=1", acks); end
        total++; if (uo_out !== 8'h29) begin bad++; $display("FAIL hold_count got=%h exp=29", uo_out); end

        send_cmd(C_STOP, 8'h00);
        send_cmd(C_PRE, 8'd3);
        send_cmd(C_LOAD, 8'h40);
        send_cmd(C_UP, 8'h00);
        repeat (2) begin @(posedge clk); #1; end
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (i == 0) uio_in = {4'b0000, 1'b1, C_STOP};
            total++; if (uo_out !== 8'h40 || uio_out[7] !== 1'b0 || uio_out[5] !== 1'b1)
                begin bad++; $display("FAIL ena_freeze i=%0d got=%h/%b exp=40/001", i, uo_out, uio_out[7:5]); end
        end
        ena = 1'b1;
        @(posedge clk); #1;
        total++; if (uo_out !== 8'h40 || uio_out[5] !== 1'b1) begin bad++; $display("FAIL ena_resume0 got=%h/%b exp=40/1", uo_out, uio_out[5]); end
        @(posedge clk); #1;
        total++; if (uo_out !== 8'h41) begin bad++; $display("FAIL ena_resume1 got=%h exp=41", uo_out); end
        uio_in = 8'h00;
        repeat (4) begin @(posedge clk); #1; end
        total++; if (uo_out !== 8'h42 || uio_out[5] !== 1'b1) begin bad++; $display("FAIL ena_resume2 got=%h/%b exp=42/1", uo_out, uio_out[5]); end
        send_cmd(C_STOP, 8'h00);
        send_cmd(C_PRE, 8'd0);
    endtask

    task automatic test_async_reset();
        send_cmd(C_LIM, 8'h80);
        send_cmd(C_LOAD, 8'h41);
        send_cmd(C_UP, 8'h00);
        @(posedge clk); #1;
        total++; if (uo_out !== 8'h42) begin bad++; $display("FAIL areset_pre got=%h exp=42", uo_out); end
        #3 rst_n = 1'b0;
        #1;
        total++; if (uo_out !== 8'h00 || uio_out[7:4] !== 4'h0) begin bad++; $display("FAIL areset_now got=%h/%h exp=00/0", uo_out, uio_out[7:4]); end
        #2 rst_n = 1'b1;
        send_cmd(C_LOAD, 8'hFE);
        send_cmd(C_UP, 8'h00);
        @(posedge clk); #1;
        total++; if (uo_out !== 8'hFF) begin bad++; $display("FAIL areset_ff got=%h exp=FF", uo_out); end
        @(posedge clk); #1;
        total++; if (uo_out !== 8'h00 || uio_out[6] !== 1'b1) begin bad++; $display("FAIL areset_limit got=%h/%b exp=00/1", uo_out, uio_out[6]); end
    endtask

    initial begin
        test_reset();
        test_run_up();
        test_prescale();
        test_run_down();
        test_oneshot();
        test_hold_ena();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
